seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 183 ++++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter feeding the sequence detectors.
// Sends a PAT_W-bit pattern MSB first, one bit per clock, repeated reps times,
// with GAP_CYCLES idle cycles between repetitions. All outputs are registered.
// Optional feature macro: SEQ_TX_PARITY_EN appends an even-parity bit to each
// repetition (state PAR).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              request, accepted only in IDLE
//   use_default        1: send DEFAULT_PAT, 0: send pattern
//   pattern            pattern captured on accepted start
//   repeat_cnt         repetitions captured on accepted start (0 -> 1)
//   abort              synchronous cancel, back to IDLE without done
//   out_seq, out_valid serial bit and its qualifier
//   busy, done         transfer in progress / one-cycle completion pulse
module seq_pattern_tx #(
    parameter int unsigned       PAT_W       = 4,
    parameter int unsigned       CNT_W       = 8,
    parameter int unsigned       GAP_CYCLES  = 0,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = PAT_W'(4'b1100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             out_seq,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
`ifdef SEQ_TX_PARITY_EN
        S_PAR,
`endif
        S_DONE
    } state_t;

    state_t           state, state_d, after_rep;
    logic [PAT_W-1:0] sh, sh_d, pat_q, pat_q_d, pat_sel;
    logic [IDX_W-1:0] idx, idx_d;
    logic [CNT_W-1:0] reps, reps_d;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
    logic             last_bit, rep_done, reload;
    logic             seq_d, valid_d, busy_d, done_d;

    assign pat_sel  = use_default ? DEFAULT_PAT : pattern;
    assign last_bit = (state == S_SHIFT) && (idx == LAST_IDX);
`ifdef SEQ_TX_PARITY_EN
    assign rep_done = (state == S_PAR);
`else
    assign rep_done = last_bit;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_d = state;
        if (reps > CNT_W'(1)) begin
            if (GAP_CYCLES == 0) after_rep = S_SHIFT;
            else                 after_rep = S_GAP;
        end else begin
            after_rep = S_DONE;
        end
        case (state)
            S_IDLE:  if (start && !abort) state_d = S_SHIFT;
            S_SHIFT: begin
                if (last_bit) begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = after_rep;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR:   state_d = after_rep;
`endif
            S_GAP:   if (gap_cnt == LAST_GAP) state_d = S_SHIFT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_d = S_IDLE;
    end

    // Datapath next values: capture, shift, reload between repetitions
    always_comb begin
        sh_d      = sh;
        pat_q_d   = pat_q;
        idx_d     = idx;
        reps_d    = reps;
        gap_cnt_d = '0;
        reload    = (state_d == S_SHIFT) && (state != S_IDLE)
                    && ((state != S_SHIFT) || last_bit);
        case (state)
            S_IDLE: begin
                if (state_d == S_SHIFT) begin
                    pat_q_d = pat_sel;
                    sh_d    = pat_sel;
                    idx_d   = '0;
                    reps_d  = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                end
            end
            S_SHIFT: begin
                sh_d  = {sh[PAT_W-2:0], 1'b0};
                idx_d = last_bit ? '0 : idx + IDX_W'(1);
            end
            S_GAP:   gap_cnt_d = gap_cnt + GAP_W'(1);
            default: ;
        endcase
        if (rep_done && (reps != '0)) reps_d = reps - CNT_W'(1);
        if (reload) begin
            sh_d  = pat_q;
            idx_d = '0;
        end
    end

    // Output decode from the upcoming state so outputs can be registered
    always_comb begin
        seq_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_SHIFT: begin
                seq_d   = sh_d[PAT_W-1];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                seq_d   = ^pat_q_d;
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
`endif
            S_GAP:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh        <= '0;
            pat_q     <= '0;
            idx       <= '0;
            reps      <= '0;
            gap_cnt   <= '0;
            out_seq   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            sh        <= sh_d;
            pat_q     <= pat_q_d;
            idx       <= idx_d;
            reps      <= reps_d;
            gap_cnt   <= gap_cnt_d;
            out_seq   <= seq_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for seq_pattern_tx (GAP_CYCLES=2).
// Each accepted start pushes the expected bit stream into a queue; a monitor
// pops on every out_valid cycle and checks busy length and done at completion.
module tb_seq_pattern_tx;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP   = 2;
    localparam logic [PAT_W-1:0] DEF = 4'b1100;
`ifdef SEQ_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             use_default = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic             abort = 1'b0;
    logic             out_seq, out_valid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];
    int exp_busy  = 0;
    int busy_cnt  = 0;
    int done_seen = 0;

    seq_pattern_tx #(
        .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYCLES(GAP), .DEFAULT_PAT(DEF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .use_default(use_default),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
        .out_seq(out_seq), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expected bits and checks each completed transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) check("extra_bit", out_valid, 0);
                else                   check("bit", out_seq, exp_q.pop_front());
            end else begin
                check("idle_seq_zero", out_seq, 0);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                check("done_busy_low", busy, 0);
                check("bits_left", exp_q.size(), 0);
                check("busy_cycles", busy_cnt, exp_busy);
                busy_cnt = 0;
            end
        end
    end

    // Reference model: whole stream from the pattern/repeat rules, then start
    task automatic launch(input logic ud, input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] c);
        logic [PAT_W-1:0] pv;
        int reps;
        @(posedge clk); #1;
        pv   = ud ? DEF : p;
        reps = (c == 0) ? 1 : int'(c);
        for (int r = 0; r < reps; r++) begin
            for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back(pv[i]);
            if (PB != 0) exp_q.push_back(^pv);
        end
        exp_busy = reps * (PAT_W + PB) + (reps - 1) * GAP;
        busy_cnt = 0;
        start = 1'b1; use_default = ud; pattern = p; repeat_cnt = c;
        @(posedge clk); #1;
        start = 1'b0;
        check("first_valid", out_valid, 1);
        check("first_busy", busy, 1);
        check("first_bit_msb", out_seq, pv[PAT_W-1]);
    endtask

    // Runs the transfer to completion; optional abort and ignored restart
    task automatic finish(input int abort_at, input bit poke);
        int  d0;
        bit  aborted;
        d0 = done_seen;
        aborted = 1'b0;
        for (int k = 1; k <= exp_busy + 4; k++) begin
            if (done_seen != d0) break;
            if (k == abort_at) abort = 1'b1;
            if (poke && k == 2) begin
                start = 1'b1; pattern = ~pattern; use_default = ~use_default;
                repeat_cnt = 8'd7;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                exp_q.delete();
                busy_cnt = 0;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            @(posedge clk); #1;
            check("abort_no_done", done_seen - d0, 0);
        end else begin
            check("done_count", done_seen - d0, 1);
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ab;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seq", out_seq, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        launch(1'b1, 4'b0000, 8'd1);  finish(0, 1'b0);
        launch(1'b0, 4'b1010, 8'd3);  finish(0, 1'b0);
        launch(1'b1, 4'b0110, 8'd0);  finish(0, 1'b1);
        launch(1'b0, 4'b1011, 8'd2);  finish(3, 1'b0);
        launch(1'b0, 4'b1001, 8'd1);  finish(0, 1'b0);

        // Asynchronous reset between clock edges in the middle of a burst
        launch(1'b0, 4'b1101, 8'd2);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_seq", out_seq, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        exp_q.delete();
        busy_cnt = 0;
        #2 rst = 1'b0;
        launch(1'b0, 4'b0111, 8'd2);  finish(0, 1'b0);
        launch(1'b0, 4'b1110, 8'd2);  finish(0, 1'b0);
        launch(1'b0, 4'b1011, 8'd255); finish(0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            launch(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom_range(0, 5)));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, exp_busy)) : 0;
            finish(ab, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
